// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt controller.
// State encoding, default trap base and cause-index width.
package irq_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REQ    = 2'd1,
      S_ACTIVE = 2'd2
   } irq_state_e;

   localparam logic [63:0] VEC_BASE_DEF = 64'h0000_0000_0000_0100;

   function automatic int cause_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
// Purely combinational, shared with the future PLIC.
module irq_prio_enc
   import irq_pkg::*;
#(
   parameter int N = 8,
   parameter int W = cause_w(N)
) (
   input  logic [N-1:0] i_req,
   output logic         o_valid,
   output logic [W-1:0] o_idx
);

   always_comb begin
      o_valid = |i_req;
      o_idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[i]) o_idx = W'(i);
      end
   end

endmodule

// File: rtl/irq_controller_mc.sv
// Multi-source interrupt controller: pending/enable, priority
// select, req/ack trap handshake with saved PC and global enable.
module irq_controller_mc
   import irq_pkg::*;
#(
   parameter int                  NUM_SRC   = 8,
   parameter int                  XLEN      = 64,
   parameter logic [NUM_SRC-1:0]  EDGE_MASK = '1,
   parameter logic [XLEN-1:0]     VEC_BASE  = XLEN'(VEC_BASE_DEF),
   parameter bit                  VECTORED  = 1'b1,
   localparam int                 CW        = cause_w(NUM_SRC)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic               en_we,
   input  logic [NUM_SRC-1:0] en_wdata,
   input  logic               gie_set,
   input  logic [XLEN-1:0]    pc_in,
   input  logic               irq_ack,
   input  logic               irq_ret,
   output logic               irq_req,
   output logic [CW-1:0]      irq_cause,
   output logic [XLEN-1:0]    trap_vector,
   output logic [XLEN-1:0]    epc,
   output logic               in_handler,
   output logic [NUM_SRC-1:0] pending,
   output logic [NUM_SRC-1:0] enable
);

   irq_state_e         r_state;
   irq_state_e         w_state_nxt;
   logic [NUM_SRC-1:0] r_src_q;
   logic [NUM_SRC-1:0] r_pend;
   logic [NUM_SRC-1:0] r_en;
   logic [NUM_SRC-1:0] w_pend_nxt;
   logic [NUM_SRC-1:0] w_rise;
   logic [NUM_SRC-1:0] w_elig;
   logic [NUM_SRC-1:0] w_clr;
   logic [CW-1:0]      r_cause;
   logic [CW-1:0]      w_cause_nxt;
   logic [CW-1:0]      w_win;
   logic [XLEN-1:0]    r_epc;
   logic               r_gie;
   logic               r_gie_sv;
   logic               r_req;
   logic               r_inh;
   logic               w_valid;
   logic               w_ack;
   logic               w_ret;
   logic               w_drop;

   assign w_rise = irq_src & ~r_src_q;
   assign w_elig = r_pend & r_en;
   assign w_ack  = (r_state == S_REQ) && irq_ack;
   assign w_ret  = (r_state == S_ACTIVE) && irq_ret;
   assign w_drop = ~w_elig[r_cause];

   always_comb begin
      w_clr = '0;
      if (w_ack) w_clr[r_cause] = 1'b1;
   end

   // A new edge in the ack cycle wins over the clear.
   assign w_pend_nxt =
      (EDGE_MASK & (w_rise | (r_pend & ~w_clr))) |
      (~EDGE_MASK & irq_src);

   irq_prio_enc #(
      .N (NUM_SRC),
      .W (CW)
   ) u_prio (
      .i_req   (w_elig),
      .o_valid (w_valid),
      .o_idx   (w_win)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cause_nxt = r_cause;
      unique case (r_state)
         S_IDLE: begin
            if (r_gie && w_valid) begin
               w_state_nxt = S_REQ;
               w_cause_nxt = w_win;
            end
         end
         S_REQ: begin
            if (irq_ack)     w_state_nxt = S_ACTIVE;
            else if (w_drop) w_state_nxt = S_IDLE;
         end
         S_ACTIVE: begin
            if (irq_ret) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_cause  <= '0;
         r_req    <= 1'b0;
         r_inh    <= 1'b0;
         r_src_q  <= '0;
         r_pend   <= '0;
         r_en     <= '0;
         r_epc    <= '0;
         r_gie    <= 1'b0;
         r_gie_sv <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cause <= w_cause_nxt;
         r_req   <= (w_state_nxt == S_REQ);
         r_inh   <= (w_state_nxt == S_ACTIVE);
         r_src_q <= irq_src;
         r_pend  <= w_pend_nxt;
         if (en_we) r_en <= en_wdata;
         if (w_ack) begin
            r_epc    <= pc_in;
            r_gie_sv <= r_gie;
            r_gie    <= 1'b0;
         end else if (w_ret) begin
            r_gie <= r_gie_sv;
         end else if (gie_set) begin
            r_gie <= 1'b1;
         end
      end
   end

   assign trap_vector = VECTORED ?
      VEC_BASE + (XLEN'(r_cause) << 2) : VEC_BASE;

   assign irq_req    = r_req;
   assign irq_cause  = r_cause;
   assign epc        = r_epc;
   assign in_handler = r_inh;
   assign pending    = r_pend;
   assign enable     = r_en;

endmodule

// File: doc/irq_controller_mc.md
# irq_controller_mc

Multi-source, parametrised interrupt controller for the 64-bit single-cycle RISC-V core. It latches up to NUM_SRC interrupt lines (edge or level per source), masks them, and selects the highest-priority pending source. It then requests a trap from the core through a req/ack handshake, saving the PC, cause and global-enable context. A return input restores that context, and the block sits between the peripheral interrupt lines and the core's PC-select/trap logic.

## Interface
- NUM_SRC, 8: number of interrupt sources, 2..32.
- XLEN, 64: PC/vector width.
- EDGE_MASK, all ones: bit i = 1 makes source i edge-triggered (rising); 0 makes it level-triggered.
- VEC_BASE, 64'h0000_0000_0000_0100: trap vector base.
- VECTORED, 1: 1 gives target = VEC_BASE + 4·cause; 0 gives target = VEC_BASE.
- clk  in  1  system clock, all state on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- irq_src  in  NUM_SRC  raw interrupt lines, synchronous to clk.
- en_we  in  1  write strobe for the enable mask.
- en_wdata  in  NUM_SRC  new per-source enable mask.
- gie_set  in  1  set the global interrupt enable (software enable).
- pc_in  in  XLEN  PC of the instruction at the current boundary.
- irq_ack  in  1  core accepts the trap this cycle.
- irq_ret  in  1  core executes the return-from-interrupt.
- irq_req  out  1  trap request to the core.
- irq_cause  out  $clog2(NUM_SRC)  index of the requested/active source.
- trap_vector  out  XLEN  handler address for irq_cause.
- epc  out  XLEN  saved PC, the return target.
- in_handler  out  1  high from ack until return.
- pending  out  NUM_SRC  pending register, for software readout.
- enable  out  NUM_SRC  current enable mask.

## Operation
- **Pending bits, edge sources:** set on a 0→1 transition of irq_src[i], detected against a registered copy of the line. Cleared on the irq_ack that selects source i. If a set and a clear hit the same cycle, set wins.
- **Pending bits, level sources:** pending[i] is the registered irq_src[i]. Level sources are never cleared by ack.
- **Eligibility:** eligible = pending & enable. Fixed priority; the lowest index wins.
- **Global enable (gie):** reset value 0. Set by gie_set. Cleared on ack. Restored on irq_ret to the value saved at ack (always 1, since a request requires gie=1).
- **FSM IDLE:** if gie && |eligible, latch irq_cause = winner and go to REQ.
- **FSM REQ:** irq_req=1. irq_cause and trap_vector hold stable until ack, even if a higher-priority source becomes pending. On irq_ack: epc←pc_in, clear edge pending[cause], gie←0, go to ACTIVE.
- **FSM REQ, eligibility lost:** if the source loses eligibility before ack (en_we masks it, or a level line drops), go back to IDLE without ack.
- **FSM ACTIVE:** in_handler=1; no nesting. On irq_ret, restore gie and go to IDLE. A new request can then issue on the next cycle.
- **Ignored inputs:** irq_ack outside REQ and irq_ret outside ACTIVE.
- **en_we:** allowed in any state; takes effect on the next edge.
- **trap_vector:** arithmetic is XLEN bits; the cause is zero-extended and shifted left by 2, and any overflow wraps.

## Timing
- **Reset values:** irq_req=0, irq_cause=0, trap_vector=VEC_BASE, epc=0, in_handler=0, pending=0, enable=0, gie=0, state IDLE.
- **Reset mid-handshake:** aborts immediately to the reset values.
- **Request latency:** an edge on irq_src in cycle N sets pending at the end of N. irq_req is high in cycle N+2 (1 cycle pending + 1 cycle FSM), provided enable and gie are set.
- **Ack:** sampled on the rising edge while irq_req=1. irq_req drops and in_handler rises in the following cycle. epc is valid from that cycle.
- **Return:** an irq_ret edge drops in_handler next cycle. The earliest next irq_req is 1 cycle after that.
- **Outputs:** all registered except trap_vector, which is combinational from irq_cause and the parameters.

## Structure
- **Package irq_pkg:** state enum (IDLE, REQ, ACTIVE), the default VEC_BASE constant, and a cause-width function.
- **Sub-module irq_prio_enc:** a parametrised fixed-priority encoder (NUM_SRC → valid + index). Purely combinational; reused by the future PLIC.
- **Everything else:** stays in the top module.

## Test plan
1. **Reset and first edge:** hold reset_n=0, then release. Check all outputs at their reset values. Then en_wdata=8'hFF, gie_set, pulse irq_src[3]. Expect irq_req in cycle N+2, irq_cause=3, trap_vector=0x10C.
2. **Simultaneous sources:** raise irq_src[5] and [2] together. Expect cause=2. Ack with pc_in=0x8000_0040. Expect epc=0x8000_0040, pending[2]=0, pending[5]=1. After irq_ret, the next request has cause=5.
3. **Level source:** EDGE_MASK bit 0=0, hold irq_src[0]=1 through ack and return. Expect pending[0] still 1 and a re-request 1 cycle after in_handler falls.
4. **Masking and gating:** en_we clears the enable of the requested source while in REQ. Expect irq_req to drop next cycle with no epc change. Separately, with gie=0, expect no irq_req despite pending.
5. **Ignored and coincident events:** irq_ret in IDLE and irq_ack in ACTIVE change nothing. An edge on the acked source in the ack cycle leaves pending set.
6. **Reset mid-handshake:** assert reset_n=0 while in ACTIVE. Expect in_handler=0, epc=0 and gie=0 asynchronously.
